lfsr_random_gen: RTL
====================

LFSR_RANDOM_GEN -- requirements
Module: lfsr_random_gen

Interface
REQ-001 Parameter WIDTH, default 7, SHALL set the LFSR and output data width (legal range 3..16).
REQ-002 Parameter TAPS, default 7'h60 (x^7+x^6+1), SHALL be the WIDTH-bit feedback tap mask.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 enable  in  1  free-run step enable in IDLE/HOLD.
REQ-006 seed_load  in  1  load seed_val into the LFSR.
REQ-007 seed_val  in  WIDTH  seed value.
REQ-008 req  in  1  request one random number.
REQ-009 min_val, max_val  in  WIDTH each  inclusive acceptance range.
REQ-010 odd_only  in  1  accept only odd values.
REQ-011 rnd_data  out  WIDTH  accepted random number.
REQ-012 rnd_valid  out  1  rnd_data is valid.
REQ-013 rnd_ready  in  1  consumer accepts rnd_data.
REQ-014 busy  out  1  high in SEARCH or HOLD.
REQ-015 err  out  1  one-cycle pulse: illegal range or search timeout.

Function
REQ-016 The LFSR step SHALL be next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)} (Fibonacci, XOR).
REQ-017 A seed_val of 0 SHALL load as 1, so the all-zero lock-up state is never entered.
REQ-018 seed_load SHALL take priority over any step in the same cycle, in every state.
REQ-019 FSM states SHALL be IDLE, SEARCH, HOLD; reset state IDLE.
REQ-020 IDLE behaviour:
- The LFSR steps when enable=1.
- On req=1 with min_val<=max_val and max_val!=0, the FSM goes to SEARCH.
- On req=1 with an illegal range, err pulses the next cycle and the FSM stays in IDLE.
REQ-021 SEARCH behaviour:
- Each cycle, lfsr is a hit if min_val<=lfsr<=max_val and (odd_only=0 or lfsr[0]=1).
- Hit: rnd_data<=lfsr, rnd_valid<=1, LFSR steps, go HOLD.
- Miss: LFSR steps regardless of enable, and the search counter increments.
REQ-022 After 2^WIDTH consecutive misses, SEARCH SHALL pulse err and return to IDLE with rnd_valid=0.
REQ-023 Latency: req sampled in cycle t and a hit on the first evaluation SHALL give rnd_valid=1 in cycle t+2.
REQ-024 HOLD behaviour:
- rnd_valid and rnd_data stay stable until rnd_valid&rnd_ready.
- After the handshake, rnd_valid=0 and the FSM is in IDLE in the next cycle.
- The LFSR steps when enable=1.
REQ-025 req SHALL be ignored outside IDLE, including a req in the handshake cycle.
REQ-026 A seed_load during SEARCH SHALL restart evaluation from the loaded value without resetting the miss counter.
REQ-027 min_val, max_val and odd_only SHALL be sampled live each SEARCH cycle; changing them mid-search is legal.
REQ-028 busy SHALL be combinationally (state!=IDLE).

Reset
REQ-029 On rst=1 at a clock edge the following SHALL hold:
- lfsr=1 and state=IDLE.
- rnd_data=0, rnd_valid=0, err=0, busy=0.
- miss counter=0.
REQ-030 A reset asserted during SEARCH or HOLD SHALL abort with no err pulse and drop rnd_valid the next cycle.

Structure
REQ-031 Package lfsr_pkg SHALL hold:
- the FSM state enum;
- the default tap constant;
- the maximal-length tap table for widths 3..16.
REQ-032 Sub-module lfsr_core SHALL implement the step, load and zero-seed substitution.
REQ-033 lfsr_random_gen SHALL hold the FSM, range check, miss counter and output register.

Verification
REQ-034 Scenario: rst, then seed_load with seed 1, then 6 cycles with enable=1 -> lfsr steps 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x41.
REQ-035 Scenario: seed 0x20, min=max=0x41, req -> rnd_valid with rnd_data=0x41 two cycles after req; held until rnd_ready=1.
REQ-036 Scenario: seed 1, min=2, max=10, odd_only=1, req -> first hit at 0x41? No: sequence 1(odd, below min), 2, 4, 8, 0x10, ... -> rnd_data odd within 3..9 per the TAPS sequence, checked by reference model; every accepted value is odd and in range.
REQ-037 Scenario: min=5, max=3, req -> err pulse one cycle, busy stays 0.
REQ-038 Scenario: min=max=4, odd_only=1, req -> err pulse after 128 SEARCH cycles, return to IDLE, rnd_valid never asserted.
REQ-039 Scenario: rst asserted mid-HOLD with rnd_ready=0 -> rnd_valid=0 and lfsr=1 the next cycle, no err; a simultaneous seed_load and req in IDLE -> search starts from the loaded seed.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random number generator:
// FSM state encoding, default feedback taps and a maximal-length tap table.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam int unsigned LFSR_MIN_WIDTH = 3;
  localparam int unsigned LFSR_MAX_WIDTH = 16;

  // x^7 + x^6 + 1
  localparam logic [6:0] DEFAULT_TAPS = 7'h60;

  // Taps for next = {lfsr[W-2:0], ^(lfsr & taps)}; bit n-1 stands for x^n.
  function automatic logic [15:0] max_len_taps(input int unsigned width);
    logic [15:0] taps;
    case (width)
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_random_gen_if.sv
// Request/response bundle between a consumer (master) and lfsr_random_gen (slave).
interface lfsr_random_gen_if #(
  parameter int unsigned WIDTH = 7
);
  logic             enable;
  logic             seed_load;
  logic [WIDTH-1:0] seed_val;
  logic             req;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;
  logic             odd_only;
  logic [WIDTH-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;
  logic             busy;
  logic             err;

  modport master (
    output enable, seed_load, seed_val, req, min_val, max_val, odd_only, rnd_ready,
    input  rnd_data, rnd_valid, busy, err
  );

  modport slave (
    input  enable, seed_load, seed_val, req, min_val, max_val, odd_only, rnd_ready,
    output rnd_data, rnd_valid, busy, err
  );
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci XOR LFSR register with seed load (zero seed replaced by 1)
// taking priority over a step.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_len_taps(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      // All-zero is the lock-up state, so it is never loaded.
      state_d = (seed_i == '0) ? WIDTH'(1) : seed_i;
    end else if (step_i) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WIDTH'(1);
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_random_gen.sv
// Searches the LFSR sequence for a value inside [min_val, max_val] (optionally
// odd only) and presents it on a valid/ready output; errors on bad range or timeout.
module lfsr_random_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_len_taps(WIDTH))
) (
  input logic               clk,
  input logic               rst,
  lfsr_random_gen_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rnd_data_q, rnd_data_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] miss_q, miss_d;
  logic [WIDTH-1:0] lfsr_w;
  logic             step;
  logic             hit;
  logic             range_ok;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (bus.seed_load),
    .step_i  (step),
    .seed_i  (bus.seed_val),
    .state_o (lfsr_w)
  );

  assign range_ok = (bus.min_val <= bus.max_val) && (bus.max_val != '0);
  assign hit      = (lfsr_w >= bus.min_val) && (lfsr_w <= bus.max_val) &&
                    (!bus.odd_only || lfsr_w[0]);

  always_comb begin
    state_d     = state_q;
    rnd_data_d  = rnd_data_q;
    rnd_valid_d = rnd_valid_q;
    err_d       = 1'b0;
    miss_d      = miss_q;
    step        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        step = bus.enable;
        if (bus.req) begin
          if (range_ok) begin
            state_d = ST_SEARCH;
            miss_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEARCH: begin
        step = 1'b1;
        if (hit) begin
          rnd_data_d  = lfsr_w;
          rnd_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (miss_q == '1) begin
          // This miss is number 2^WIDTH in a row: give up.
          err_d   = 1'b1;
          miss_d  = '0;
          state_d = ST_IDLE;
        end else begin
          miss_d = miss_q + WIDTH'(1);
        end
      end
      ST_HOLD: begin
        step = bus.enable;
        if (rnd_valid_q && bus.rnd_ready) begin
          rnd_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      rnd_data_q  <= rnd_data_d;
      rnd_valid_q <= rnd_valid_d;
      err_q       <= err_d;
      miss_q      <= miss_d;
    end
  end

  assign bus.rnd_data  = rnd_data_q;
  assign bus.rnd_valid = rnd_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
